// File: rtl/dc_slot_allocator.sv
// Round-robin write-side arbiter and slot allocator for a token-addressed buffer.
// Two one-hot rotating tokens select the next slot to write and the oldest slot to read.
module dc_slot_allocator #(
    parameter  int BUFFER_DEPTH = 8,
    parameter  int NUM_REQ      = 4,
    localparam int CNT_W        = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [BUFFER_DEPTH-1:0] alloc_slot,
    input  logic                    release_en,   // consumer frees the oldest allocated slot
    output logic [BUFFER_DEPTH-1:0] release_slot,
    output logic [CNT_W-1:0]        count,
    output logic                    full,
    output logic                    empty,
    output logic                    release_err
);

    // Handshake: req is a level held until gnt; gnt is combinational in the same
    // cycle and a grant consumes the slot shown on alloc_slot in that cycle.
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]        ptr;
    logic [PTR_W-1:0]        ptr_next;
    logic [PTR_W-1:0]        win_idx;
    logic                    grant_fire;
    logic                    rel_fire;
    logic [CNT_W-1:0]        count_next;
    logic [BUFFER_DEPTH-1:0] alloc_next;
    logic [BUFFER_DEPTH-1:0] release_next;
    logic                    err_next;
    int                      idx;

    assign full  = (count == CNT_W'(BUFFER_DEPTH));
    assign empty = (count == '0);

    // Search upward from the priority pointer, wrapping at NUM_REQ-1.
    always_comb begin
        gnt        = '0;
        win_idx    = '0;
        grant_fire = 1'b0;
        idx        = 0;
        if (!rst && !full) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!grant_fire && req[idx]) begin
                    gnt[idx]   = 1'b1;
                    win_idx    = PTR_W'(idx);
                    grant_fire = 1'b1;
                end
            end
        end
    end

    assign rel_fire = release_en && !empty;

    always_comb begin
        ptr_next     = ptr;
        alloc_next   = alloc_slot;
        release_next = release_slot;
        count_next   = count;
        err_next     = release_err;

        if (grant_fire) begin
            if (int'(win_idx) == NUM_REQ - 1) begin
                ptr_next = '0;
            end else begin
                ptr_next = win_idx + PTR_W'(1);
            end
            alloc_next = {alloc_slot[BUFFER_DEPTH-2:0], alloc_slot[BUFFER_DEPTH-1]};
        end

        if (rel_fire) begin
            release_next = {release_slot[BUFFER_DEPTH-2:0], release_slot[BUFFER_DEPTH-1]};
        end

        // A release against an empty buffer is ignored but remembered.
        if (release_en && empty) begin
            err_next = 1'b1;
        end

        case ({grant_fire, rel_fire})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            alloc_slot   <= BUFFER_DEPTH'(1);
            release_slot <= BUFFER_DEPTH'(1);
            count        <= '0;
            release_err  <= 1'b0;
        end else begin
            ptr          <= ptr_next;
            alloc_slot   <= alloc_next;
            release_slot <= release_next;
            count        <= count_next;
            release_err  <= err_next;
        end
    end

    function automatic logic [BUFFER_DEPTH-1:0] rotl(input logic [BUFFER_DEPTH-1:0] v,
                                                     input logic [CNT_W-1:0] n);
        logic [BUFFER_DEPTH-1:0] r;
        r = v;
        for (int i = 0; i < BUFFER_DEPTH; i++) begin
            if (i < int'(n)) begin
                r = {r[BUFFER_DEPTH-2:0], r[BUFFER_DEPTH-1]};
            end
        end
        return r;
    endfunction

    // Structural invariants of the token pair and the counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot(alloc_slot));
            assert ($onehot(release_slot));
            assert ($onehot0(gnt));
            assert (count <= CNT_W'(BUFFER_DEPTH));
            assert (alloc_slot == rotl(release_slot, count));
        end
    end

endmodule

// File: tb/tb_dc_slot_allocator.sv
// Randomized and directed bench for dc_slot_allocator, scored against a
// queue-of-allocated-slots reference model.
module tb_dc_slot_allocator;

    localparam int D  = 8;
    localparam int N  = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          release_en;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [D-1:0]  alloc_slot;
    logic [D-1:0]  release_slot;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          release_err;

    int checks = 0;
    int errors = 0;

    dc_slot_allocator #(.BUFFER_DEPTH(D), .NUM_REQ(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .gnt          (gnt),
        .alloc_slot   (alloc_slot),
        .release_en   (release_en),
        .release_slot (release_slot),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .release_err  (release_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit           chk;
        logic [N-1:0] g;
        logic [D-1:0] a;
        logic [D-1:0] r;
        int           c;
        bit           f;
        bit           e;
        bit           err;
    } stat_t;

    stat_t            stat_q[$];
    logic [N+D-1:0]   exp_q[$];     // {gnt, alloc_slot} per expected grant

    bit           m_known = 1'b0;
    int           m_ptr   = 0;
    int           m_alloc = 0;
    int           m_q[$];           // allocated slot indices, oldest first
    bit           m_err   = 1'b0;
    logic [N-1:0] last_gnt = '0;
    logic [N-1:0] rq;

    function automatic logic [D-1:0] onehot(input int i);
        logic [D-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic [N-1:0] r_req, input logic r_rel, input logic r_rst);
        stat_t s;
        int    w;
        @(negedge clk);
        req        = r_req;
        release_en = r_rel;
        rst        = r_rst;

        s.chk = m_known;
        s.a   = onehot(m_alloc);
        s.r   = (m_q.size() > 0) ? onehot(m_q[0]) : onehot(m_alloc);
        s.c   = m_q.size();
        s.f   = (s.c == D);
        s.e   = (s.c == 0);
        s.err = m_err;
        s.g   = '0;

        if (r_rst) begin
            m_known = 1'b1;
            m_ptr   = 0;
            m_alloc = 0;
            m_q.delete();
            m_err   = 1'b0;
        end else begin
            w = -1;
            if (m_q.size() < D) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (w < 0 && r_req[j]) w = j;
                end
            end
            if (w >= 0) begin
                s.g = N'(1) << w;
                exp_q.push_back({s.g, s.a});
                m_q.push_back(m_alloc);
                m_alloc = (m_alloc + 1) % D;
                m_ptr   = (w + 1) % N;
            end
            if (r_rel) begin
                if (s.c > 0) void'(m_q.pop_front());
                else         m_err = 1'b1;
            end
        end
        last_gnt = s.g;
        stat_q.push_back(s);
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
        end
    endtask

    initial begin
        stat_t          s;
        logic [N+D-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                chk("gnt_any", 32'(|gnt), 32'(|s.g));
                if (|gnt) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", 32'({gnt, alloc_slot}), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant_and_slot", 32'({gnt, alloc_slot}), 32'(e));
                    end
                end
                if (s.chk) begin
                    chk("alloc_slot",   32'(alloc_slot),   32'(s.a));
                    chk("release_slot", 32'(release_slot), 32'(s.r));
                    chk("count",        32'(count),        32'(s.c));
                    chk("full",         32'(full),         32'(s.f));
                    chk("empty",        32'(empty),        32'(s.e));
                    chk("release_err",  32'(release_err),  32'(s.err));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int rel_pct;
        rst        = 1'b1;
        req        = '0;
        release_en = 1'b0;
        rq         = '0;

        // Reset and idle
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        repeat (5) step(4'b0000, 1'b0, 1'b0);

        // Fill to full with all requesters active, then one blocked cycle
        repeat (9) step(4'b1111, 1'b0, 1'b0);

        // Release while full: grant only on the following cycle
        step(4'b0001, 1'b1, 1'b0);
        repeat (2) step(4'b0001, 1'b0, 1'b0);

        // count=3, simultaneous grant and release for 4 cycles, then pointer at 3
        step(4'b0000, 1'b0, 1'b1);
        repeat (3) step(4'b1111, 1'b0, 1'b0);
        repeat (4) step(4'b0100, 1'b1, 1'b0);
        step(4'b1111, 1'b0, 1'b0);

        // Release while empty sets the sticky error; reset clears it
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b1, 1'b0);
        repeat (3) step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);

        // Reset mid-operation at count=5 beats grant and release
        repeat (5) step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        // Randomized traffic with varying release pressure
        step(4'b0000, 1'b0, 1'b1);
        for (int ph = 0; ph < 6; ph++) begin
            case (ph % 3)
                0:       rel_pct = 20;
                1:       rel_pct = 50;
                default: rel_pct = 85;
            endcase
            for (int i = 0; i < 500; i++) begin
                rq = rq & ~last_gnt;
                rq = rq | N'($urandom_range(0, 15) & $urandom_range(0, 15));
                if ($urandom_range(0, 9) == 0) rq = rq & N'($urandom_range(0, 15));
                step(rq, ($urandom_range(0, 99) < rel_pct), ($urandom_range(0, 399) == 0));
            end
        end
        step(4'b0000, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #3;
        chk("grant_queue_drained", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
